processor_mc: RTL
=================

PROCESSOR_MC -- requirements
Module: processor_mc

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL provide parameter TIMEOUT, default 16, the maximum number of cycles to wait for mem_ready; 0 disables the timeout.
REQ-003 SHALL provide port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port en  input  1  core enable; low freezes all state.
REQ-006 SHALL provide port mem_addr  output  32  unified instruction/data memory address.
REQ-007 SHALL provide port mem_wdata  output  32  store data.
REQ-008 SHALL provide port mem_rdata  input  32  fetch/load data, valid when mem_ready=1.
REQ-009 SHALL provide port mem_read  output  1  read request.
REQ-010 SHALL provide port mem_write  output  1  write request.
REQ-011 SHALL provide port mem_ready  input  1  memory completes the pending request this cycle.
REQ-012 SHALL provide port pc_out  output  32  current PC.
REQ-013 SHALL provide port halted  output  1  unsupported instruction decoded; sticky.
REQ-014 SHALL provide port error  output  1  bus timeout or misaligned access; sticky.

Function
REQ-015 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR, plus internal 32x32 register file, IR, A, B, ALUOut, MDR registers.
REQ-016 FETCH SHALL drive mem_read=1 and mem_addr=PC; on mem_ready it latches IR=mem_rdata, sets PC=PC+4 (mod 2^32) and goes to DECODE.
REQ-017 DECODE SHALL latch A=reg[rs] and B=reg[rt], and sign-extend imm[15:0]; an unsupported opcode/funct goes to HALT.
REQ-018 Supported instructions: R-type (op 0x00) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
REQ-019 EXEC for R-type/addi SHALL compute into ALUOut (wrap-around, no overflow trap) and go to WB.
REQ-020 EXEC for lw/sw SHALL set ALUOut=A+sext(imm); if ALUOut[1:0]!=0 it goes to ERROR without issuing an access, else to MEM.
REQ-021 EXEC for beq SHALL set PC=PC+(sext(imm)<<2) if A==B, then go to FETCH.
REQ-022 EXEC for j SHALL set PC={PC[31:28],target,2'b00} and go to FETCH.
REQ-023 MEM for lw SHALL drive mem_read=1, mem_addr=ALUOut; on mem_ready it latches MDR and goes to WB.
REQ-024 MEM for sw SHALL drive mem_write=1, mem_addr=ALUOut, mem_wdata=B; on mem_ready it goes to FETCH.
REQ-025 WB SHALL write rd (R-type) or rt (addi, lw), then go to FETCH.
REQ-026 Writes to reg 0 SHALL be discarded; reg 0 always reads 0.
REQ-027 Latency with zero-wait memory: R-type/addi 4, lw 5, sw 4, beq/j 3 cycles; each wait cycle adds 1.
REQ-028 mem_read/mem_write/mem_addr/mem_wdata SHALL be held stable until the cycle mem_ready=1 is sampled; mem_read and mem_write are never both 1.
REQ-029 mem_ready SHALL be ignored when no request is asserted.
REQ-030 When TIMEOUT>0, a wait counter SHALL count cycles with an outstanding request and no mem_ready; reaching TIMEOUT goes to ERROR and deasserts the requests the next cycle; the counter clears on each completed request.
REQ-031 When en=0, state, PC, registers and the wait counter SHALL hold, and the outputs SHALL hold their values, including any outstanding request; mem_ready is not consumed.
REQ-032 HALT and ERROR SHALL be terminal until reset; no memory requests are issued in them.
REQ-033 halted=1 exactly in HALT and error=1 exactly in ERROR.

Reset
REQ-034 When rst_n=0 at a clock edge, the block SHALL set PC=RESET_PC, state=FETCH, clear all GPRs, IR, A, B, ALUOut, MDR and the wait counter, and drive halted=0 and error=0.
REQ-035 A reset mid-transaction SHALL abandon the transaction; the request is reissued as a fetch from RESET_PC.
REQ-036 Reset SHALL take priority over en.

Verification
REQ-037 Zero-wait memory; program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x10($0); lw $4,0x10($0) -> write to 0x10 of 12; $4=12; 4+4+4+4+5 cycles.
REQ-038 beq $0,$0,-1 at 0x8 -> PC returns to 0x8 every 3 cycles; j 0x100 -> next fetch address 0x400.
REQ-039 mem_ready delayed 3 cycles on a fetch, TIMEOUT=16 -> mem_read and mem_addr stable 4 cycles; then normal progress.
REQ-040 mem_ready held low with TIMEOUT=4 -> error=1 after 4 wait cycles; requests low after; held until rst_n=0.
REQ-041 lw $1,2($0) -> error=1 with no mem_read in MEM; opcode 0x3F -> halted=1.
REQ-042 en=0 during a MEM wait, then rst_n=0 -> state frozen while en=0; after reset pc_out=RESET_PC and the first fetch is issued.

Source files
------------

// File: rtl/processor_mc.sv
// Multi-cycle MIPS-subset core on a single unified memory bus with a ready handshake.
// Every bus output is registered and is computed from the next-state values.
module processor_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1);

    function automatic logic insn_supported(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: ok = 1'b1;
                    default:                          ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] alu_rtype(input logic [5:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (fn)
            F_ADD:   r = a + b;
            F_SUB:   r = a - b;
            F_AND:   r = a & b;
            F_OR:    r = a | b;
            F_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_t      state_r, state_n_s;
    logic [31:0] pc_r, pc_n_s;
    logic [31:0] ir_r, ir_n_s;
    logic [31:0] a_r, a_n_s;
    logic [31:0] b_r, b_n_s;
    logic [31:0] alu_out_r, alu_n_s;
    logic [31:0] mdr_r, mdr_n_s;
    logic [31:0] wait_cnt_r, wait_n_s;
    logic [31:0] regs_r [32];

    logic        mem_read_r, mem_read_n_s;
    logic        mem_write_r, mem_write_n_s;
    logic [31:0] mem_addr_r, mem_addr_n_s;
    logic [31:0] mem_wdata_r, mem_wdata_n_s;
    logic        halted_r, error_r;

    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s;
    logic [31:0] imm_sext_s, ea_s, rs_val_s, rt_val_s;
    logic        timeout_hit_s;

    assign opcode_s   = ir_r[31:26];
    assign rs_s       = ir_r[25:21];
    assign rt_s       = ir_r[20:16];
    assign rd_s       = ir_r[15:11];
    assign funct_s    = ir_r[5:0];
    assign imm_sext_s = {{16{ir_r[15]}}, ir_r[15:0]};
    assign ea_s       = a_r + imm_sext_s;
    assign rs_val_s   = (rs_s == 5'd0) ? 32'd0 : regs_r[rs_s];
    assign rt_val_s   = (rt_s == 5'd0) ? 32'd0 : regs_r[rt_s];
    assign timeout_hit_s = (TIMEOUT != 32'd0) && (wait_cnt_r == TIMEOUT_LAST);

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_n_s  = state_r;
        pc_n_s     = pc_r;
        ir_n_s     = ir_r;
        a_n_s      = a_r;
        b_n_s      = b_r;
        alu_n_s    = alu_out_r;
        mdr_n_s    = mdr_r;
        wait_n_s   = wait_cnt_r;
        rf_we_s    = 1'b0;
        rf_waddr_s = 5'd0;
        rf_wdata_s = 32'd0;

        case (state_r)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_n_s    = mem_rdata;
                    pc_n_s    = pc_r + 32'd4;
                    wait_n_s  = 32'd0;
                    state_n_s = ST_DECODE;
                end else if (timeout_hit_s) begin
                    state_n_s = ST_ERROR;
                end else begin
                    wait_n_s = wait_cnt_r + 32'd1;
                end
            end
            ST_DECODE: begin
                a_n_s = rs_val_s;
                b_n_s = rt_val_s;
                if (insn_supported(opcode_s, funct_s)) begin
                    state_n_s = ST_EXEC;
                end else begin
                    state_n_s = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (opcode_s)
                    OP_RTYPE: begin
                        alu_n_s   = alu_rtype(funct_s, a_r, b_r);
                        state_n_s = ST_WB;
                    end
                    OP_ADDI: begin
                        alu_n_s   = ea_s;
                        state_n_s = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_n_s = ea_s;
                        // A misaligned address never reaches the bus.
                        if (ea_s[1:0] != 2'b00) begin
                            state_n_s = ST_ERROR;
                        end else begin
                            state_n_s = ST_MEM;
                        end
                    end
                    OP_BEQ: begin
                        if (a_r == b_r) begin
                            pc_n_s = pc_r + {imm_sext_s[29:0], 2'b00};
                        end else begin
                            pc_n_s = pc_r;
                        end
                        state_n_s = ST_FETCH;
                    end
                    OP_J: begin
                        pc_n_s    = {pc_r[31:28], ir_r[25:0], 2'b00};
                        state_n_s = ST_FETCH;
                    end
                    default: state_n_s = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    wait_n_s = 32'd0;
                    if (opcode_s == OP_LW) begin
                        mdr_n_s   = mem_rdata;
                        state_n_s = ST_WB;
                    end else begin
                        state_n_s = ST_FETCH;
                    end
                end else if (timeout_hit_s) begin
                    state_n_s = ST_ERROR;
                end else begin
                    wait_n_s = wait_cnt_r + 32'd1;
                end
            end
            ST_WB: begin
                rf_we_s   = 1'b1;
                state_n_s = ST_FETCH;
                case (opcode_s)
                    OP_RTYPE: begin
                        rf_waddr_s = rd_s;
                        rf_wdata_s = alu_out_r;
                    end
                    OP_LW: begin
                        rf_waddr_s = rt_s;
                        rf_wdata_s = mdr_r;
                    end
                    default: begin
                        rf_waddr_s = rt_s;
                        rf_wdata_s = alu_out_r;
                    end
                endcase
            end
            ST_HALT:  state_n_s = ST_HALT;
            ST_ERROR: state_n_s = ST_ERROR;
            default:  state_n_s = ST_ERROR;
        endcase

        mem_read_n_s  = (state_n_s == ST_FETCH) || ((state_n_s == ST_MEM) && (opcode_s == OP_LW));
        mem_write_n_s = (state_n_s == ST_MEM) && (opcode_s == OP_SW);
        if (state_n_s == ST_FETCH) begin
            mem_addr_n_s = pc_n_s;
        end else if (state_n_s == ST_MEM) begin
            mem_addr_n_s = alu_n_s;
        end else begin
            mem_addr_n_s = mem_addr_r;
        end
        if (mem_write_n_s) begin
            mem_wdata_n_s = b_r;
        end else begin
            mem_wdata_n_s = mem_wdata_r;
        end
    end

    // State, datapath, register file and bus registers; en=0 freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            ir_r        <= 32'd0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            alu_out_r   <= 32'd0;
            mdr_r       <= 32'd0;
            wait_cnt_r  <= 32'd0;
            mem_read_r  <= 1'b1;
            mem_write_r <= 1'b0;
            mem_addr_r  <= RESET_PC;
            mem_wdata_r <= 32'd0;
            halted_r    <= 1'b0;
            error_r     <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_r[i[4:0]] <= 32'd0;
            end
        end else if (en) begin
            state_r     <= state_n_s;
            pc_r        <= pc_n_s;
            ir_r        <= ir_n_s;
            a_r         <= a_n_s;
            b_r         <= b_n_s;
            alu_out_r   <= alu_n_s;
            mdr_r       <= mdr_n_s;
            wait_cnt_r  <= wait_n_s;
            mem_read_r  <= mem_read_n_s;
            mem_write_r <= mem_write_n_s;
            mem_addr_r  <= mem_addr_n_s;
            mem_wdata_r <= mem_wdata_n_s;
            halted_r    <= (state_n_s == ST_HALT);
            error_r     <= (state_n_s == ST_ERROR);
            if (rf_we_s && (rf_waddr_s != 5'd0)) begin
                regs_r[rf_waddr_s] <= rf_wdata_s;
            end
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign pc_out    = pc_r;
    assign halted    = halted_r;
    assign error     = error_r;

endmodule
